// File: rtl/front_panel_ctrl_if.sv
// CPU-side bundle of the front-panel controller: command strobes, memory
// write/read ports, step handshake and display selection.
interface front_panel_ctrl_if;
    logic        cpu_busy;
    logic        step_ack;
    logic        pc_load;
    logic        ac_load;
    logic [11:0] load_val;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_raddr;
    logic        step_req;
    logic [1:0]  disp_sel;
    logic [11:0] panel_addr;

    modport master (
        input  cpu_busy, step_ack,
        output pc_load, ac_load, load_val, mem_we, mem_waddr, mem_wdata,
               mem_raddr, step_req, disp_sel, panel_addr
    );

    modport slave (
        output cpu_busy, step_ack,
        input  pc_load, ac_load, load_val, mem_we, mem_waddr, mem_wdata,
               mem_raddr, step_req, disp_sel, panel_addr
    );
endinterface

// File: rtl/front_panel_ctrl.sv
// Front-panel controller: synchronizes and debounces the five panel buttons and
// turns each debounced press into a single CPU command (load, deposit, step, display).
module front_panel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  btnCpuReset,
    input  logic                  btnc,
    input  logic                  btnu,
    input  logic                  btnd,
    input  logic                  btnl,
    input  logic                  btnr,
    input  logic [12:0]           sw,
    front_panel_ctrl_if.master    cpu
);

    localparam int NumBtn = 5;
    localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StStepWait} state_e;

    // Button order: {c, u, d, l, r}
    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q, sync2_q, level_q, press_q;
    logic [7:0]        cnt_q [NumBtn];
    logic              sw_unused;

    assign btn_raw   = {btnc, btnu, btnd, btnl, btnr};
    assign sw_unused = sw[12];

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < NumBtn; i++) cnt_q[i] <= 8'd0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NumBtn; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= 8'd0;
                end else if (cnt_q[i] == CntLast) begin
                    level_q[i] <= sync2_q[i];
                    cnt_q[i]   <= 8'd0;
                    press_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    logic press_c, press_u, press_d, press_l, press_r;
    assign {press_c, press_u, press_d, press_l, press_r} = press_q;

    state_e      state_q;
    logic        pc_load_q, ac_load_q, mem_we_q, step_req_q;
    logic [11:0] load_val_q, mem_waddr_q, mem_wdata_q, panel_addr_q;
    logic [1:0]  disp_sel_q;
    logic [11:0] addr_cur;

    // The increment lands on the edge closing the mem_we cycle; look ahead so a
    // deposit accepted on that same edge uses the advanced address.
    assign addr_cur = mem_we_q ? panel_addr_q + 12'd1 : panel_addr_q;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state_q      <= StIdle;
            pc_load_q    <= 1'b0;
            ac_load_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            step_req_q   <= 1'b0;
            load_val_q   <= 12'd0;
            mem_waddr_q  <= 12'd0;
            mem_wdata_q  <= 12'd0;
            panel_addr_q <= 12'd0;
            disp_sel_q   <= 2'd0;
        end else begin
            pc_load_q <= 1'b0;
            ac_load_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (press_c) disp_sel_q <= disp_sel_q + 2'd1;
            if (mem_we_q) panel_addr_q <= panel_addr_q + 12'd1;
            unique case (state_q)
                StIdle: begin
                    if (!cpu.cpu_busy) begin
                        if (press_l) begin
                            pc_load_q    <= 1'b1;
                            load_val_q   <= sw[11:0];
                            panel_addr_q <= sw[11:0];
                        end else if (press_r) begin
                            ac_load_q  <= 1'b1;
                            load_val_q <= sw[11:0];
                        end else if (press_d) begin
                            mem_waddr_q <= addr_cur;
                            mem_wdata_q <= sw[11:0];
                            state_q     <= StWrite;
                        end else if (press_u) begin
                            step_req_q <= 1'b1;
                            state_q    <= StStepWait;
                        end
                    end
                end
                StWrite: begin
                    mem_we_q <= 1'b1;
                    state_q  <= StIdle;
                end
                StStepWait: begin
                    if (cpu.step_ack) begin
                        step_req_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu.pc_load    = pc_load_q;
    assign cpu.ac_load    = ac_load_q;
    assign cpu.load_val   = load_val_q;
    assign cpu.mem_we     = mem_we_q;
    assign cpu.mem_waddr  = mem_waddr_q;
    assign cpu.mem_wdata  = mem_wdata_q;
    assign cpu.step_req   = step_req_q;
    assign cpu.disp_sel   = disp_sel_q;
    assign cpu.panel_addr = panel_addr_q;
    assign cpu.mem_raddr  = (disp_sel_q == 2'd3) ? sw[11:0] : panel_addr_q;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Bench for front_panel_ctrl: table of button commands with a scoreboard of expected
// strobes, plus hand sequences for latency, step handshake, display and reset cases.
module tb_front_panel_ctrl;

    localparam int BR = 0;
    localparam int BL = 1;
    localparam int BD = 2;
    localparam int BU = 3;
    localparam int BC = 4;

    localparam logic [1:0] KPc   = 2'd0;
    localparam logic [1:0] KAc   = 2'd1;
    localparam logic [1:0] KWe   = 2'd2;
    localparam logic [1:0] KStep = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  btn = '0;
    logic [12:0] sw = '0;

    front_panel_ctrl_if bus ();

    front_panel_ctrl #(.DEBOUNCE_CYCLES(5)) dut (
        .clk         (clk),
        .btnCpuReset (rst_n),
        .btnc        (btn[BC]),
        .btnu        (btn[BU]),
        .btnd        (btn[BD]),
        .btnl        (btn[BL]),
        .btnr        (btn[BR]),
        .sw          (sw),
        .cpu         (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [11:0] data;
        logic [11:0] addr;
    } ev_t;

    typedef struct {
        int          b;
        logic [11:0] swv;
        bit          busy;
        bit          has_ev;
        ev_t         ev;
    } vec_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic step_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o required %0o", name, act, exp);
        end
    endtask

    task automatic take(input string name, input logic [1:0] kind, input logic [11:0] data,
                        input logic [11:0] addr);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected %s: got data %0o addr %0o required no strobe",
                     name, data, addr);
        end else begin
            e = exp_q.pop_front();
            check({name, " kind"}, 32'(kind), 32'(e.kind));
            check({name, " data"}, 32'(data), 32'(e.data));
            check({name, " addr"}, 32'(addr), 32'(e.addr));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.pc_load) take("pc_load", KPc, bus.load_val, bus.panel_addr);
            if (bus.ac_load) take("ac_load", KAc, bus.load_val, bus.panel_addr);
            if (bus.mem_we)  take("mem_we", KWe, bus.mem_wdata, bus.mem_waddr);
            if (bus.step_req && !step_prev) take("step_req", KStep, 12'd0, 12'd0);
        end
        step_prev = bus.step_req;
    end

    task automatic press(input int b, input int hold);
        @(negedge clk);
        btn[b] = 1'b1;
        repeat (hold) @(negedge clk);
        btn[b] = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    vec_t vecs[7];
    int   lat;

    initial begin
        vecs[0] = '{BL, 12'o0200, 1'b0, 1'b1, '{KPc, 12'o0200, 12'o0200}};
        vecs[1] = '{BR, 12'o0055, 1'b0, 1'b1, '{KAc, 12'o0055, 12'o0200}};
        vecs[2] = '{BL, 12'o7776, 1'b0, 1'b1, '{KPc, 12'o7776, 12'o7776}};
        vecs[3] = '{BD, 12'o1234, 1'b0, 1'b1, '{KWe, 12'o1234, 12'o7776}};
        vecs[4] = '{BD, 12'o4321, 1'b0, 1'b1, '{KWe, 12'o4321, 12'o7777}};
        vecs[5] = '{BR, 12'o0777, 1'b1, 1'b0, '{KAc, 12'o0, 12'o0}};
        vecs[6] = '{BD, 12'o0111, 1'b1, 1'b0, '{KWe, 12'o0, 12'o0}};

        bus.cpu_busy = 1'b0;
        bus.step_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset pc_load", 32'(bus.pc_load), 0);
        check("reset ac_load", 32'(bus.ac_load), 0);
        check("reset mem_we", 32'(bus.mem_we), 0);
        check("reset step_req", 32'(bus.step_req), 0);
        check("reset disp_sel", 32'(bus.disp_sel), 0);
        check("reset panel_addr", 32'(bus.panel_addr), 0);
        check("reset load_val", 32'(bus.load_val), 0);
        check("reset mem_waddr", 32'(bus.mem_waddr), 0);
        check("reset mem_wdata", 32'(bus.mem_wdata), 0);
        check("reset mem_raddr", 32'(bus.mem_raddr), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Press latency: pc_load one edge after the press pulse at cycle 2+5.
        sw = {1'b0, 12'o0100};
        exp_q.push_back('{KPc, 12'o0100, 12'o0100});
        @(negedge clk);
        btn[BL] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.pc_load) begin
                lat = i;
                break;
            end
        end
        check("press latency", 32'(lat), 8);
        repeat (5) @(negedge clk);
        btn[BL] = 1'b0;
        repeat (15) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            sw = {1'b0, vecs[i].swv};
            bus.cpu_busy = vecs[i].busy;
            if (vecs[i].has_ev) exp_q.push_back(vecs[i].ev);
            press(vecs[i].b, 10);
            bus.cpu_busy = 1'b0;
        end
        check("panel_addr wrap", 32'(bus.panel_addr), 0);

        // Step handshake; a deposit during the wait is discarded.
        exp_q.push_back('{KStep, 12'o0, 12'o0});
        press(BU, 10);
        check("step_req held", 32'(bus.step_req), 1);
        sw = {1'b0, 12'o0666};
        press(BD, 10);
        check("step_req after dropped deposit", 32'(bus.step_req), 1);
        @(negedge clk);
        bus.step_ack = 1'b1;
        @(posedge clk);
        #1;
        check("step_req after ack", 32'(bus.step_req), 0);
        @(negedge clk);
        bus.step_ack = 1'b0;
        sw = {1'b0, 12'o0321};
        exp_q.push_back('{KAc, 12'o0321, 12'o0000});
        press(BR, 10);

        // Display cycling and memory read address selection.
        repeat (3) press(BC, 10);
        check("disp_sel after 3", 32'(bus.disp_sel), 3);
        for (int i = 0; i < 8; i++) begin
            sw = 13'(i);
            #1;
            check("mem_raddr tracks sw", 32'(bus.mem_raddr), 32'(i));
        end
        bus.cpu_busy = 1'b1;
        press(BC, 10);
        bus.cpu_busy = 1'b0;
        check("disp_sel wrap", 32'(bus.disp_sel), 0);
        sw = {1'b0, 12'o0555};
        #1;
        check("mem_raddr panel", 32'(bus.mem_raddr), 0);

        // Load PC and Deposit settle together: only Load PC fires.
        sw = {1'b0, 12'o0500};
        exp_q.push_back('{KPc, 12'o0500, 12'o0500});
        @(negedge clk);
        btn[BL] = 1'b1;
        btn[BD] = 1'b1;
        repeat (10) @(negedge clk);
        btn[BL] = 1'b0;
        btn[BD] = 1'b0;
        repeat (15) @(negedge clk);
        check("panel_addr after tie", 32'(bus.panel_addr), 32'(12'o0500));

        // Short bounce: no pulse.
        press(BR, 3);

        // Two-cycle glitch inside a held press: a single pulse.
        sw = {1'b0, 12'o0600};
        exp_q.push_back('{KPc, 12'o0600, 12'o0600});
        @(negedge clk);
        btn[BL] = 1'b1;
        repeat (10) @(negedge clk);
        btn[BL] = 1'b0;
        repeat (2) @(negedge clk);
        btn[BL] = 1'b1;
        repeat (10) @(negedge clk);
        btn[BL] = 1'b0;
        repeat (15) @(negedge clk);

        // Asynchronous reset while waiting for step_ack.
        press(BC, 10);
        check("disp_sel before reset", 32'(bus.disp_sel), 1);
        exp_q.push_back('{KStep, 12'o0, 12'o0});
        press(BU, 10);
        check("step_req before reset", 32'(bus.step_req), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("step_req async reset", 32'(bus.step_req), 0);
        check("disp_sel async reset", 32'(bus.disp_sel), 0);
        check("panel_addr async reset", 32'(bus.panel_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        mon_en = 1'b0;
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
